complex_mult_pipe: RTL and testbench

Parametrised, fully pipelined signed complex multiplier with valid/ready handshaking, optional conjugation of the second operand, fixed-point rescaling with round-half-up, and an overflow flag. It computes (a1 + b1 i)·(a2 ± b2 i) at one result per cycle. It replaces fixed 8-bit, free-running complex multipliers in datapaths that need back-pressure, wider operands or Q-format scaling, such as mixers, FFT twiddle stages and correlators.

---
 rtl/cmult_pkg.sv | 30 +++
 rtl/cmult_scale.sv | 43 ++++
 rtl/complex_mult_pipe.sv | 122 ++++++++++++
 tb/tb_complex_mult_pipe.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/cmult_pkg.sv
// Shared widths, rounding constants and helpers for the pipelined complex multiplier.
package cmult_pkg;

    // A product of two DW-bit operands needs PROD_MUL*DW bits; a sum of two products one more.
    localparam int PROD_MUL = 2;
    localparam int SUM_GROW = 1;
    // The rounding add gets one guard bit so it can never wrap.
    localparam int RND_GROW = 1;
    localparam int RND_ONE  = 1;

    function automatic int prod_w(input int dw);
        return PROD_MUL * dw;
    endfunction

    function automatic int sum_w(input int dw);
        return PROD_MUL * dw + SUM_GROW;
    endfunction

    function automatic int rnd_pos(input int frac);
        return (frac > 0) ? frac - 1 : 0;
    endfunction

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/cmult_scale.sv
// Per-component round-half-up, arithmetic shift by FRAC and range reduction to OW bits.
// CMULT_SAT_EN selects clamping; otherwise the low OW bits are kept.
module cmult_scale
    import cmult_pkg::*;
#(
    parameter int SW   = 17,
    parameter int OW   = 8,
    parameter int FRAC = 0
) (
    input  logic [SW-1:0] sum_i,
    output logic [OW-1:0] res_o,
    output logic          ovf_o
);

    localparam int XW = SW + RND_GROW;
    localparam logic [XW-1:0] RND_OFS = (FRAC > 0) ? (XW'(RND_ONE) << rnd_pos(FRAC)) : '0;
    localparam logic [OW-1:0] MAX_V = {1'b0, {(OW-1){1'b1}}};
    localparam logic [OW-1:0] MIN_V = {1'b1, {(OW-1){1'b0}}};

    logic signed [XW-1:0] ext_s;
    logic signed [XW-1:0] rnd_s;
    logic signed [XW-1:0] shf_s;
    logic [XW-OW:0]       hi_bits;

    always_comb begin
        ext_s   = $signed({sum_i[SW-1], sum_i});
        rnd_s   = ext_s + $signed(RND_OFS);
        shf_s   = rnd_s >>> FRAC;
        // In range only when every bit from OW-1 upward matches the sign.
        hi_bits = shf_s[XW-1:OW-1];
        ovf_o   = ~((&hi_bits) | (~|hi_bits));
`ifdef CMULT_SAT_EN
        if (ovf_o) begin
            res_o = shf_s[XW-1] ? MIN_V : MAX_V;
        end else begin
            res_o = shf_s[OW-1:0];
        end
`else
        res_o = shf_s[OW-1:0];
`endif
    end

endmodule

// File: rtl/complex_mult_pipe.sv
// Pipelined signed complex multiplier (a1+b1i)*(a2+-b2i) with valid/ready and global stall.
// Stages: operands, products, sums, scaled output. CMULT_SAT_EN selects clamping in cmult_scale.
module complex_mult_pipe
    import cmult_pkg::*;
#(
    parameter int DW   = 8,
    parameter int OW   = 8,
    parameter int FRAC = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] a1,
    input  logic [DW-1:0] b1,
    input  logic [DW-1:0] a2,
    input  logic [DW-1:0] b2,
    input  logic          conj_b,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [OW-1:0] res_re,
    output logic [OW-1:0] res_im,
    output logic          out_ovf
);

    localparam int PW = prod_w(DW);
    localparam int SW = sum_w(DW);

    logic          stall;
    logic          v1_q, v1_d, v2_q, v2_d, v3_q, v3_d, out_valid_q, out_valid_d;
    logic [DW-1:0] a1_q, a1_d, b1_q, b1_d, a2_q, a2_d, b2_q, b2_d;
    logic          conj1_q, conj1_d, conj2_q, conj2_d;
    logic [PW-1:0] p_aa_q, p_aa_d, p_bb_q, p_bb_d, p_ab_q, p_ab_d, p_ba_q, p_ba_d;
    logic [SW-1:0] re_q, re_d, im_q, im_d;
    logic [OW-1:0] res_re_q, res_re_d, res_im_q, res_im_d;
    logic          ovf_q, ovf_d;
    logic [OW-1:0] scl_re, scl_im;
    logic          ovf_re, ovf_im;

    assign stall     = out_valid_q && !out_ready;
    assign in_ready  = !stall;
    assign out_valid = out_valid_q;
    assign res_re    = res_re_q;
    assign res_im    = res_im_q;
    assign out_ovf   = ovf_q;

    cmult_scale #(.SW(SW), .OW(OW), .FRAC(FRAC)) u_scale_re (
        .sum_i (re_q),
        .res_o (scl_re),
        .ovf_o (ovf_re)
    );

    cmult_scale #(.SW(SW), .OW(OW), .FRAC(FRAC)) u_scale_im (
        .sum_i (im_q),
        .res_o (scl_im),
        .ovf_o (ovf_im)
    );

    always_comb begin
        v1_d = v1_q;  v2_d = v2_q;  v3_d = v3_q;  out_valid_d = out_valid_q;
        a1_d = a1_q;  b1_d = b1_q;  a2_d = a2_q;  b2_d = b2_q;
        conj1_d = conj1_q;  conj2_d = conj2_q;
        p_aa_d = p_aa_q;  p_bb_d = p_bb_q;  p_ab_d = p_ab_q;  p_ba_d = p_ba_q;
        re_d = re_q;  im_d = im_q;
        res_re_d = res_re_q;  res_im_d = res_im_q;  ovf_d = ovf_q;

        // Data registers only load behind a valid beat so idle outputs keep their last result.
        if (!stall) begin
            v1_d        = in_valid;
            v2_d        = v1_q;
            v3_d        = v2_q;
            out_valid_d = v3_q;
            if (in_valid) begin
                a1_d    = a1;
                b1_d    = b1;
                a2_d    = a2;
                b2_d    = b2;
                conj1_d = conj_b;
            end
            if (v1_q) begin
                p_aa_d  = PW'($signed(a1_q)) * PW'($signed(a2_q));
                p_bb_d  = PW'($signed(b1_q)) * PW'($signed(b2_q));
                p_ab_d  = PW'($signed(a1_q)) * PW'($signed(b2_q));
                p_ba_d  = PW'($signed(a2_q)) * PW'($signed(b1_q));
                conj2_d = conj1_q;
            end
            if (v2_q) begin
                if (conj2_q) begin
                    re_d = SW'($signed(p_aa_q)) + SW'($signed(p_bb_q));
                    im_d = SW'($signed(p_ba_q)) - SW'($signed(p_ab_q));
                end else begin
                    re_d = SW'($signed(p_aa_q)) - SW'($signed(p_bb_q));
                    im_d = SW'($signed(p_ab_q)) + SW'($signed(p_ba_q));
                end
            end
            if (v3_q) begin
                res_re_d = scl_re;
                res_im_d = scl_im;
                ovf_d    = ovf_re | ovf_im;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q <= 1'b0;  v2_q <= 1'b0;  v3_q <= 1'b0;  out_valid_q <= 1'b0;
            a1_q <= '0;  b1_q <= '0;  a2_q <= '0;  b2_q <= '0;
            conj1_q <= 1'b0;  conj2_q <= 1'b0;
            p_aa_q <= '0;  p_bb_q <= '0;  p_ab_q <= '0;  p_ba_q <= '0;
            re_q <= '0;  im_q <= '0;
            res_re_q <= '0;  res_im_q <= '0;  ovf_q <= 1'b0;
        end else begin
            v1_q <= v1_d;  v2_q <= v2_d;  v3_q <= v3_d;  out_valid_q <= out_valid_d;
            a1_q <= a1_d;  b1_q <= b1_d;  a2_q <= a2_d;  b2_q <= b2_d;
            conj1_q <= conj1_d;  conj2_q <= conj2_d;
            p_aa_q <= p_aa_d;  p_bb_q <= p_bb_d;  p_ab_q <= p_ab_d;  p_ba_q <= p_ba_d;
            re_q <= re_d;  im_q <= im_d;
            res_re_q <= res_re_d;  res_im_q <= res_im_d;  ovf_q <= ovf_d;
        end
    end

endmodule

// File: tb/tb_complex_mult_pipe.sv
// Scoreboard bench for complex_mult_pipe: directed beats, FRAC=7 rounding, back-pressure and reset flush.
module tb_complex_mult_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       in_valid, in_ready, conj_b, out_valid, out_ready, out_ovf;
    logic [7:0] a1, b1, a2, b2, res_re, res_im;
    logic       in_valid_f, in_ready_f, out_valid_f, out_ovf_f;
    logic       out_ready_f = 1'b1;
    logic       conj_f      = 1'b0;
    logic [7:0] a1_f, b1_f, a2_f, b2_f, res_re_f, res_im_f;

    complex_mult_pipe #(.DW(8), .OW(8), .FRAC(0)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a1(a1), .b1(b1), .a2(a2), .b2(b2), .conj_b(conj_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .res_re(res_re), .res_im(res_im), .out_ovf(out_ovf)
    );

    complex_mult_pipe #(.DW(8), .OW(8), .FRAC(7)) dut7 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_f), .in_ready(in_ready_f),
        .a1(a1_f), .b1(b1_f), .a2(a2_f), .b2(b2_f), .conj_b(conj_f),
        .out_valid(out_valid_f), .out_ready(out_ready_f),
        .res_re(res_re_f), .res_im(res_im_f), .out_ovf(out_ovf_f)
    );

    typedef struct {
        int re;
        int im;
        bit ovf;
        int acc;
        bit chk_lat;
    } exp_t;

    exp_t sb_q[$];
    exp_t sb7_q[$];
    exp_t mon_e, mon7_e;
    int   n_chk = 0, n_fail = 0, cyc = 0, stall_cnt = 0;
    bit   done = 1'b0;

`ifdef CMULT_SAT_EN
    localparam int IM_BIG = 127;
    localparam int RE_SQ  = 127;
`else
    localparam int IM_BIG = 32;
    localparam int RE_SQ  = 0;
`endif

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && !done) begin
            if (out_valid && !out_ready) stall_cnt++;
            chk("in_ready_vs_stall", int'(in_ready), int'(!(out_valid && !out_ready)));
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                end else begin
                    mon_e = sb_q.pop_front();
                    chk("res_re", $signed(res_re), mon_e.re);
                    chk("res_im", $signed(res_im), mon_e.im);
                    chk("out_ovf", int'(out_ovf), int'(mon_e.ovf));
                    if (mon_e.chk_lat) chk("latency", cyc - mon_e.acc, 3);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && !done && out_valid_f) begin
            if (sb7_q.size() == 0) begin
                chk("unexpected_result_frac7", 1, 0);
            end else begin
                mon7_e = sb7_q.pop_front();
                chk("frac7_re", $signed(res_re_f), mon7_e.re);
                chk("frac7_im", $signed(res_im_f), mon7_e.im);
                chk("frac7_ovf", int'(out_ovf_f), int'(mon7_e.ovf));
            end
        end
    end

    task automatic send(input int va1, input int vb1, input int va2, input int vb2, input bit cj,
                        input int ere, input int eim, input bit eovf, input bit lat);
        exp_t e;
        int   tries;
        tries = 0;
        @(negedge clk);
        a1 = va1[7:0];  b1 = vb1[7:0];  a2 = va2[7:0];  b2 = vb2[7:0];
        conj_b = cj;  in_valid = 1'b1;
        while (!in_ready && tries < 50) begin
            @(negedge clk);
            tries++;
        end
        if (!in_ready) begin
            chk("send_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        e = '{ere, eim, eovf, cyc + 1, lat};
        sb_q.push_back(e);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic send7(input int va1, input int va2, input int ere);
        exp_t e;
        @(negedge clk);
        a1_f = va1[7:0];  b1_f = 8'd0;  a2_f = va2[7:0];  b2_f = 8'd0;  in_valid_f = 1'b1;
        e = '{ere, 0, 1'b0, cyc + 1, 1'b0};
        sb7_q.push_back(e);
        @(posedge clk);
        #1 in_valid_f = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((sb_q.size() != 0 || sb7_q.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() != 0 || sb7_q.size() != 0) chk("drain_timeout", 0, 1);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;  in_valid = 1'b0;  conj_b = 1'b0;  out_ready = 1'b1;
        a1 = '0;  b1 = '0;  a2 = '0;  b2 = '0;
        in_valid_f = 1'b0;  a1_f = '0;  b1_f = '0;  a2_f = '0;  b2_f = '0;
        #3;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_res_re", int'(res_re), 0);
        chk("rst_res_im", int'(res_im), 0);
        chk("rst_out_ovf", int'(out_ovf), 0);
        chk("rst_out_valid_frac7", int'(out_valid_f), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("in_ready_after_reset", int'(in_ready), 1);

        send(3, 4, 5, -2, 1'b0, 23, 14, 1'b0, 1'b1);
        wait_drain();
        send(3, 4, 5, -2, 1'b1, 7, 26, 1'b0, 1'b1);
        send(100, 100, 100, 100, 1'b0, 0, IM_BIG, 1'b1, 1'b1);
        send(-128, 0, -128, 0, 1'b0, RE_SQ, 0, 1'b1, 1'b1);
        send(-128, 0, 127, 0, 1'b0, -128, 0, 1'b1, 1'b1);
        send(-1, -1, 1, 1, 1'b0, 0, -2, 1'b0, 1'b1);
        wait_drain();

        send7(96, 1, 1);
        send7(65, 65, 33);
        send7(-96, 1, -1);
        wait_drain();

        stall_cnt = 0;
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    if (i % 2 == 1) send(i, i - 4, 3, -2, 1'b1, i + 8, 5 * i - 12, 1'b0, 1'b0);
                    else            send(i, i - 4, 3, -2, 1'b0, 5 * i - 8, i - 12, 1'b0, 1'b0);
                end
            end
            begin
                for (int c = 0; c < 16; c++) begin
                    @(posedge clk);
                    #1 out_ready = !(c >= 4 && c <= 8);
                end
            end
        join
        wait_drain();
        chk("stall_seen", int'(stall_cnt > 0), 1);

        send(3, 4, 5, -2, 1'b0, 23, 14, 1'b0, 1'b0);
        send(1, 1, 1, 1, 1'b0, 0, 2, 1'b0, 1'b0);
        send(2, 0, 2, 0, 1'b0, 4, 0, 1'b0, 1'b0);
        rst_n = 1'b0;
        sb_q.delete();
        #1;
        chk("flush_out_valid", int'(out_valid), 0);
        chk("flush_res_re", int'(res_re), 0);
        chk("flush_res_im", int'(res_im), 0);
        chk("flush_out_ovf", int'(out_ovf), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("no_stale_result", int'(out_valid), 0);
        end
        send(3, 4, 5, -2, 1'b1, 7, 26, 1'b0, 1'b1);
        wait_drain();

        done = 1'b1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
